// File: rtl/tmds_rx_aligner.sv
// rtl/tmds_rx_aligner.sv - TMDS receive character aligner and decoder
// Hunts for control-token runs, requests bitslips, decodes locked characters.
module tmds_rx_aligner #(
  parameter int MIN_RUN   = 8,
  parameter int TIMEOUT   = 4096,
  parameter int SLIP_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tmds_i,
  output logic       bitslip_o,
  output logic       locked_o,
  output logic       de_o,
  output logic [7:0] data_o,
  output logic [1:0] ctrl_o,
  output logic [3:0] slip_count_o,
  output logic [7:0] loss_count_o
);

  localparam int RW = $clog2(MIN_RUN + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_SLIP, ST_WAIT, ST_LOCKED} state_t;

  state_t        state_q, state_d;
  logic [9:0]    s1_word_q;
  logic          s1_ctrl_q, in_ctrl;
  logic [1:0]    s1_tok_q, in_tok;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]    slip_q, slip_d;
  logic [7:0]    loss_q, loss_d;
  logic          de_q, de_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [7:0]    q_word, dec;
  logic          run_complete, timeout, loss_event, locked;

  always_comb begin
    in_ctrl = 1'b1;
    in_tok  = 2'b00;
    case (tmds_i)
      10'b1101010100: in_tok = 2'b00;
      10'b0010101011: in_tok = 2'b01;
      10'b0101010100: in_tok = 2'b10;
      10'b1010101011: in_tok = 2'b11;
      default:        in_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    q_word = s1_word_q[9] ? ~s1_word_q[7:0] : s1_word_q[7:0];
    dec    = 8'h00;
    dec[0] = q_word[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = s1_word_q[8] ? (q_word[i] ^ q_word[i-1]) : ~(q_word[i] ^ q_word[i-1]);
    end
  end

  // The run counter is frozen in WAIT, so a run can only complete outside it.
  assign run_complete = s1_ctrl_q && (run_q == RW'(MIN_RUN - 1)) && (state_q != ST_WAIT);
  assign timeout      = (timer_q == TW'(TIMEOUT - 1));
  assign loss_event   = (state_q == ST_LOCKED) && timeout && !run_complete;
  assign locked       = (state_q == ST_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_SEARCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (run_complete)  state_d = ST_LOCKED;
        else if (timeout)  state_d = ST_SLIP;
      end
      ST_SLIP:   state_d = ST_WAIT;
      ST_WAIT:   if (wait_q == WW'(SLIP_WAIT - 1)) state_d = ST_SEARCH;
      ST_LOCKED: if (loss_event) state_d = ST_SEARCH;
      default:   state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    bitslip_o = (state_q == ST_SLIP);
    locked_o  = locked;
  end

  always_comb begin
    run_d = '0;
    if (state_q != ST_WAIT && !loss_event && s1_ctrl_q) begin
      run_d = (run_q == RW'(MIN_RUN)) ? run_q : run_q + RW'(1);
    end

    timer_d = timer_q + TW'(1);
    if (state_q == ST_SLIP || state_q == ST_WAIT || run_complete || timeout) timer_d = '0;

    wait_d = (state_q == ST_WAIT) ? wait_q + WW'(1) : '0;

    slip_d = slip_q;
    if (state_q == ST_SLIP) slip_d = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;

    loss_d = loss_q;
    if (loss_event && loss_q != 8'hFF) loss_d = loss_q + 8'd1;

    de_d   = locked && !s1_ctrl_q;
    data_d = (locked && !s1_ctrl_q) ? dec : 8'h00;
    ctrl_d = !locked ? 2'b00 : (s1_ctrl_q ? s1_tok_q : ctrl_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_word_q <= '0;
      s1_ctrl_q <= 1'b0;
      s1_tok_q  <= '0;
      run_q     <= '0;
      timer_q   <= '0;
      wait_q    <= '0;
      slip_q    <= '0;
      loss_q    <= '0;
      de_q      <= 1'b0;
      data_q    <= '0;
      ctrl_q    <= '0;
    end else begin
      s1_word_q <= tmds_i;
      s1_ctrl_q <= in_ctrl;
      s1_tok_q  <= in_tok;
      run_q     <= run_d;
      timer_q   <= timer_d;
      wait_q    <= wait_d;
      slip_q    <= slip_d;
      loss_q    <= loss_d;
      de_q      <= de_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign de_o         = de_q;
  assign data_o       = data_q;
  assign ctrl_o       = ctrl_q;
  assign slip_count_o = slip_q;
  assign loss_count_o = loss_q;

endmodule

// File: tb/tb_tmds_rx_aligner.sv
// tb/tb_tmds_rx_aligner.sv - self-checking bench for tmds_rx_aligner
// Vector table plus scoreboard queue and hand-written lock/slip/loss/reset sequences.
module tb_tmds_rx_aligner;

  localparam logic [9:0] TOK0  = 10'b1101010100;
  localparam logic [9:0] DATA0 = 10'b0100000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds_i = '0;
  logic       bitslip_o, locked_o, de_o;
  logic [7:0] data_o, loss_count_o;
  logic [1:0] ctrl_o;
  logic [3:0] slip_count_o;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  typedef struct {
    logic       chk;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  typedef struct {
    logic [9:0] w;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[13];

  tmds_rx_aligner #(.MIN_RUN(8), .TIMEOUT(64), .SLIP_WAIT(4)) dut (
    .clk(clk), .rst(rst), .tmds_i(tmds_i), .bitslip_o(bitslip_o),
    .locked_o(locked_o), .de_o(de_o), .data_o(data_o), .ctrl_o(ctrl_o),
    .slip_count_o(slip_count_o), .loss_count_o(loss_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic cyc(input logic [9:0] w, input logic chk, input logic de,
                     input logic [7:0] d, input logic [1:0] c);
    exp_t e;
    tmds_i = w;
    e.chk = chk; e.de = de; e.data = d; e.ctrl = c;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    if (sbq.size() >= 2) begin
      e = sbq.pop_front();
      if (e.chk) begin
        check("sb_de", de_o, e.de);
        check("sb_data", data_o, e.data);
        check("sb_ctrl", ctrl_o, e.ctrl);
      end
    end
  endtask

  task automatic run(input logic [9:0] w);
    cyc(w, 1'b0, 1'b0, 8'h00, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tmds_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    cyc_n = 0;
  endtask

  task automatic wait_locked(input logic val, input int bound, input logic [9:0] w, input string name);
    int n = 0;
    while (locked_o !== val && n < bound) begin
      run(w);
      n++;
    end
    check(name, locked_o, val);
  endtask

  function automatic logic [9:0] rot(input logic [9:0] w, input int o);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) r[j] = w[(j + o) % 10];
    return r;
  endfunction

  initial begin
    int lock_cyc, pulses, last_pulse, pend, o, n;
    logic seen_lock;

    vecs[0]  = '{10'b1101010100, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{10'b0100000000, 1'b1, 8'h00, 2'd0};
    vecs[2]  = '{10'b1011111111, 1'b1, 8'hFE, 2'd0};
    vecs[3]  = '{10'b1010101011, 1'b0, 8'h00, 2'd3};
    vecs[4]  = '{10'b0111111111, 1'b1, 8'h01, 2'd3};
    vecs[5]  = '{10'b0010101011, 1'b0, 8'h00, 2'd1};
    vecs[6]  = '{10'b1100000000, 1'b1, 8'h01, 2'd1};
    vecs[7]  = '{10'b0101010100, 1'b0, 8'h00, 2'd2};
    vecs[8]  = '{10'b0000000000, 1'b1, 8'hFE, 2'd2};
    vecs[9]  = '{10'b0100000001, 1'b1, 8'h03, 2'd2};
    vecs[10] = '{10'b0101010101, 1'b1, 8'hFF, 2'd2};
    vecs[11] = '{10'b0001010101, 1'b1, 8'h01, 2'd2};
    vecs[12] = '{10'b1001010101, 1'b1, 8'h00, 2'd2};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_locked", locked_o, 0);
    check("rst_bitslip", bitslip_o, 0);
    check("rst_de", de_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ctrl", ctrl_o, 0);
    check("rst_slip_count", slip_count_o, 0);
    check("rst_loss_count", loss_count_o, 0);

    // Aligned stream, lock timing, decode table
    do_reset();
    lock_cyc = -1;
    for (int j = 0; j < 12; j++) begin
      cyc(TOK0, 1'b1, 1'b0, 8'h00, 2'b00);
      check("lock_time", locked_o, (j >= 8) ? 1 : 0);
      if (locked_o && lock_cyc < 0) lock_cyc = cyc_n;
    end
    cyc(DATA0, 1'b1, 1'b1, 8'h00, 2'b00);
    foreach (vecs[i]) cyc(vecs[i].w, 1'b1, vecs[i].de, vecs[i].data, vecs[i].ctrl);
    cyc(DATA0, 1'b1, 1'b1, 8'h00, 2'd2);
    check("aligned_slip_count", slip_count_o, 0);

    // Lock loss timing
    n = 0;
    while (locked_o && n < 200) begin
      run(DATA0);
      n++;
    end
    check("loss_time", cyc_n, lock_cyc + 64);
    check("loss_count_1", loss_count_o, 1);
    repeat (3) run(DATA0);
    check("loss_de", de_o, 0);
    check("loss_data", data_o, 0);

    // Saturating loss counter
    for (int k = 0; k < 256; k++) begin
      wait_locked(1'b1, 20, TOK0, "sat_relock");
      wait_locked(1'b0, 80, DATA0, "sat_drop");
    end
    check("loss_count_sat", loss_count_o, 255);

    // Reset mid-LOCKED
    wait_locked(1'b1, 20, TOK0, "pre_rst_lock");
    run(10'b0111111111);
    run(10'b0111111111);
    check("pre_rst_de", de_o, 1);
    #2 rst = 1'b1;
    #1;
    check("rstL_locked", locked_o, 0);
    check("rstL_de", de_o, 0);
    check("rstL_data", data_o, 0);
    check("rstL_loss_count", loss_count_o, 0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    cyc_n = 0;
    for (int j = 0; j < 9; j++) begin
      run(TOK0);
      check("relock_time", locked_o, (j >= 8) ? 1 : 0);
    end

    // Misaligned by 3 bits, bench slips one bit per pulse
    do_reset();
    o = 3; pulses = 0; last_pulse = 0; pend = -1; n = 0;
    while (!locked_o && n < 1000) begin
      run(rot(TOK0, o));
      n++;
      if (bitslip_o) begin
        pulses++;
        if (pulses > 1) check("mis_spacing", cyc_n - last_pulse, 69);
        last_pulse = cyc_n;
        o = (o + 1) % 10;
        pend = cyc_n + 2;
      end
      if (cyc_n == pend) check("mis_slip_count", slip_count_o, pulses % 10);
    end
    check("mis_locked", locked_o, 1);
    check("mis_pulses", pulses, 7);
    check("mis_final_slip_count", slip_count_o, 7);

    // Near-miss runs of 7: never lock, slip at cycle 64, count wraps after 10
    do_reset();
    pulses = 0; last_pulse = 0; seen_lock = 1'b0; n = 0;
    while (pulses < 10 && n < 800) begin
      run((n % 8 < 7) ? TOK0 : DATA0);
      n++;
      if (locked_o) seen_lock = 1'b1;
      if (bitslip_o) begin
        pulses++;
        if (pulses == 1) check("nm_first_slip", cyc_n, 64);
        else check("nm_spacing", cyc_n - last_pulse, 69);
        last_pulse = cyc_n;
        run(DATA0);
        n++;
        check("nm_pulse_width", bitslip_o, 0);
      end
    end
    run(DATA0);
    check("nm_pulses", pulses, 10);
    check("nm_wrap", slip_count_o, 0);
    check("nm_never_lock", seen_lock, 0);

    // Run of exactly 8 completing on the timeout cycle
    do_reset();
    pulses = 0;
    for (int j = 0; j < 72; j++) begin
      run((j >= 55 && j <= 62) ? TOK0 : DATA0);
      if (bitslip_o) pulses++;
      if (j == 62) check("tc_not_yet", locked_o, 0);
      if (j == 63) check("tc_locked", locked_o, 1);
    end
    check("tc_no_slip", pulses, 0);
    check("tc_slip_count", slip_count_o, 0);

    // Reset mid-WAIT
    do_reset();
    n = 0;
    while (!bitslip_o && n < 100) begin
      run(DATA0);
      n++;
    end
    check("pre_wait_slip", bitslip_o, 1);
    run(DATA0);
    run(DATA0);
    check("pre_wait_count", slip_count_o, 1);
    #2 rst = 1'b1;
    #1;
    check("rstW_bitslip", bitslip_o, 0);
    check("rstW_slip_count", slip_count_o, 0);
    check("rstW_locked", locked_o, 0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    cyc_n = 0;
    for (int j = 0; j < 9; j++) begin
      run(TOK0);
      check("rstW_relock", locked_o, (j >= 8) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_rx_aligner.md
# tmds_rx_aligner

Receive-side counterpart of the DVI/HDMI TMDS transmit path: takes 10-bit parallel TMDS characters from one channel's deserializer, finds character alignment by hunting for blanking control-token runs, drives a bitslip request back to the deserializer, and decodes locked characters to 8-bit pixel data or 2-bit control. It sits between the per-channel ISERDES chain and the video timing/capture logic. The block is used for HDMI loopback test of the transmitter and as the front end of a future capture path.

## Interface
Parameters:
- MIN_RUN, 8, consecutive control tokens required to declare/refresh lock
- TIMEOUT, 4096, cycles without a qualifying run before slip (SEARCH) or lock loss (LOCKED); must exceed one video line
- SLIP_WAIT, 4, cycles to ignore input after a bitslip pulse (deserializer settling)

Ports:
- clk  in  1  pixel clock; all logic single-clock
- rst  in  1  asynchronous, active-high reset
- tmds_i  in  10  raw character from deserializer, bit 0 first on the wire
- bitslip_o  out  1  one-cycle request to rotate deserializer by one bit
- locked_o  out  1  character alignment established
- de_o  out  1  data_o valid (video data character)
- data_o  out  8  decoded pixel byte
- ctrl_o  out  2  decoded {C1,C0} control bits
- slip_count_o  out  4  bitslips issued, modulo 10 (9 wraps to 0)
- loss_count_o  out  8  lock-loss events, saturating at 255

## Operation
- Control tokens (bit9..bit0): 1101010100→00, 0010101011→01, 0101010100→10, 1010101011→11. Any other word is data.
- Data decode: q = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0]; data[0]=q[0]; data[i] = tmds_i[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), i=1..7.
- Stage 1 registers tmds_i and its classification (is_ctrl, token value). Stage 2 registers decoded outputs.
- Run counter: increments on each stage-1 control token, clears on any stage-1 data word; saturates at MIN_RUN. "Run complete" = counter reaches MIN_RUN on this edge (fires once per run).
- FSM states: SEARCH, SLIP, WAIT, LOCKED.
  - SEARCH: timer increments each cycle. Run complete → LOCKED, timer cleared. Else timer == TIMEOUT-1 → SLIP. Run complete wins over timeout on the same cycle.
  - SLIP: bitslip_o=1 for exactly this cycle; slip_count_o increments (mod 10); → WAIT.
  - WAIT: run counter and timer held at 0; after SLIP_WAIT cycles → SEARCH.
  - LOCKED: timer increments; run complete clears timer. Timer == TIMEOUT-1 without run complete → SEARCH, loss_count_o increments, run counter cleared. No bitslip in LOCKED.
- Outputs: locked_o = (state == LOCKED). When stage-2 word is taken while not locked: de_o=0, data_o=0, ctrl_o=0. When locked: control word → de_o=0, ctrl_o=token, data_o=0; data word → de_o=1, data_o=decode, ctrl_o holds last token value.

## Timing
- Reset (async assert, sync-safe release): state SEARCH, all counters 0, all outputs 0.
- Latency: word present before edge k → stage 1 at edge k → de_o/data_o/ctrl_o valid after edge k+1 (2 cycles).
- Lock: tokens present before edges n..n+MIN_RUN-1 → locked_o high after edge n+MIN_RUN.
- Search period without lock: TIMEOUT cycles SEARCH + 1 SLIP + SLIP_WAIT WAIT; bitslip pulses spaced TIMEOUT+1+SLIP_WAIT cycles.
- Lock loss: locked_o falls TIMEOUT cycles after the last run-complete edge; loss_count_o updates on the same edge.
- rst asserted mid-operation: immediate return to reset values, including counters; bitslip_o never stretched.

## Test plan
Bench parameters MIN_RUN=8, TIMEOUT=64, SLIP_WAIT=4 unless noted.
- Aligned: 12× 1101010100 then 0100000000 → locked_o high 8 cycles after the first token's edge; ctrl_o=00; data word gives de_o=1, data_o=0x00 two cycles after presentation; slip_count_o=0.
- Decode: locked, feed 1011111111 → data_o=0xFE, de_o=1; feed 1010101011 → de_o=0, ctrl_o=11.
- Misaligned: stream rotated 3 bits, bench rotates by one bit per bitslip_o pulse → pulses spaced 69 cycles, lock within ≤9 slips, slip_count_o equals pulse count mod 10; 10 pulses wrap count to 0.
- Near-miss: repeating 7 tokens + 1 data word → never locks; bitslip_o at cycle 64; run of exactly 8 arriving on the timeout cycle → locks, no slip.
- Loss: locked, then data words only → locked_o falls 64 cycles after the last run completes; loss_count_o=1; de_o=0 thereafter; 256 losses → loss_count_o stays 255.
- Reset mid-LOCKED and mid-WAIT → all outputs 0 immediately; aligned stream after release relocks in 8 cycles.
